// File: rtl/except_ctrl.sv
// MEM-stage exception arbiter: synchronises interrupts, prioritises exceptions, issues flush/redirect.
// Optional feature: define CP0_TIMER_INT_EN to OR timer_int_i into IP7.
module except_ctrl #(
    parameter logic [31:0] EXC_VEC_BOOT = 32'hBFC00380,
    parameter logic [31:0] EXC_VEC_NORM = 32'h80000180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_i,
    input  logic        timer_int_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic [5:0]  mem_exc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  int_sync_o,
    output logic [31:0] except_type_o,
    output logic [31:0] pc_o,
    output logic        is_in_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    localparam logic [4:0] AddrStatus = 5'd12;
    localparam logic [4:0] AddrCause  = 5'd13;
    localparam logic [4:0] AddrEpc    = 5'd14;

    typedef enum logic {StIdle, StSquash} state_e;

    state_e      state_q, state_d;
    logic [5:0]  int_meta_q, int_sync_q;
    logic        int_pending_q, int_pending_d;
    logic [31:0] status_fwd, epc_fwd;
    logic [1:0]  cause_ip_fwd;
    logic [7:0]  ip;
    logic        int_req;
    logic [31:0] code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            int_meta_q    <= '0;
            int_sync_q    <= '0;
            int_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            int_meta_q    <= int_i;
            int_sync_q    <= int_meta_q;
            int_pending_q <= int_pending_d;
        end
    end

    assign int_sync_o = int_sync_q;

    // Forward in-flight WB writes so the decision sees this cycle's CP0 values.
    always_comb begin
        status_fwd   = (wb_cp0_we_i && wb_cp0_waddr_i == AddrStatus) ? wb_cp0_data_i : cp0_status_i;
        epc_fwd      = (wb_cp0_we_i && wb_cp0_waddr_i == AddrEpc) ? wb_cp0_data_i : cp0_epc_i;
        cause_ip_fwd = (wb_cp0_we_i && wb_cp0_waddr_i == AddrCause) ? wb_cp0_data_i[9:8]
                                                                     : cp0_cause_i[9:8];
    end

`ifdef CP0_TIMER_INT_EN
    assign ip = {int_sync_q[5] | timer_int_i, int_sync_q[4:0], cause_ip_fwd};
`else
    assign ip = {int_sync_q, cause_ip_fwd};
    logic unused_timer;
    assign unused_timer = timer_int_i;
`endif

    logic unused_bits;
    assign unused_bits = ^{cp0_cause_i[31:10], cp0_cause_i[7:0], status_fwd[31:23],
                           status_fwd[21:16], status_fwd[7:2]};

    assign int_req = status_fwd[0] & ~status_fwd[1] & |(ip & status_fwd[15:8]);

    always_comb begin
        code = 32'h0;
        if (state_q == StIdle && mem_valid_i) begin
            if (int_req || int_pending_q) code = 32'h01;
            else if (mem_exc_i[0])        code = 32'h0a;
            else if (mem_exc_i[1])        code = 32'h08;
            else if (mem_exc_i[2])        code = 32'h09;
            else if (mem_exc_i[3])        code = 32'h0d;
            else if (mem_exc_i[4])        code = 32'h0c;
            else if (mem_exc_i[5])        code = 32'h0e;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (code != 32'h0) state_d = StSquash;
            StSquash: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Pending remembers an interrupt raised while MEM held a bubble.
    always_comb begin
        int_pending_d = int_pending_q;
        if (state_q == StIdle) begin
            if (code == 32'h01 || !int_req) int_pending_d = 1'b0;
            else if (!mem_valid_i)          int_pending_d = 1'b1;
        end
    end

    always_comb begin
        except_type_o     = 32'h0;
        pc_o              = 32'h0;
        is_in_delayslot_o = 1'b0;
        flush_o           = 1'b0;
        new_pc_o          = 32'h0;
        if (!rst) begin
            except_type_o     = code;
            pc_o              = mem_pc_i;
            is_in_delayslot_o = mem_in_delayslot_i;
            flush_o           = (code != 32'h0);
            if (code == 32'h0e)      new_pc_o = epc_fwd;
            else if (code != 32'h0)  new_pc_o = status_fwd[22] ? EXC_VEC_BOOT : EXC_VEC_NORM;
        end
    end

endmodule

// File: doc/except_ctrl.md
Name: except_ctrl

Overview:
- Exception arbiter in the MEM stage; drives the exception inputs of the CP0 register block and consumes its Status/Cause/EPC outputs.
- Synchronises the external interrupt lines and prioritises MEM-stage exception flags against pending interrupts.
- Forwards in-flight WB-stage CP0 writes so decisions use current values.
- Issues pipeline flush and redirect PC, then runs a one-cycle squash window.

Parameters:
- EXC_VEC_BOOT, 32'hBFC00380, exception vector when Status.BEV=1
- EXC_VEC_NORM, 32'h80000180, exception vector when Status.BEV=0

Ports:
- clk  in  1  clock
- rst  in  1  reset
- int_i  in  6  external interrupt lines, asynchronous
- timer_int_i  in  1  timer interrupt from CP0; used only with the optional feature
- mem_valid_i  in  1  a real instruction occupies MEM this cycle
- mem_pc_i  in  32  PC of the MEM instruction
- mem_in_delayslot_i  in  1  MEM instruction is in a delay slot
- mem_exc_i  in  6  one-hot-ish flags {eret, overflow, trap, break, syscall, inst_invalid}, bits [5:0]
- wb_cp0_we_i  in  1  CP0 write in WB
- wb_cp0_waddr_i  in  5  CP0 write address
- wb_cp0_data_i  in  32  CP0 write data
- cp0_status_i  in  32  CP0 Status
- cp0_cause_i  in  32  CP0 Cause
- cp0_epc_i  in  32  CP0 EPC
- int_sync_o  out  6  synchronised interrupt lines, feeding the CP0 int input
- except_type_o  out  32  exception code to CP0
- pc_o  out  32  PC to CP0
- is_in_delayslot_o  out  1  delay-slot flag to CP0
- flush_o  out  1  flush all stages up to MEM
- new_pc_o  out  32  redirect target, valid when flush_o=1

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high. Every flop clears on rst high, independent of clk.
- Reset values:
  - int_sync_o=0, except_type_o=0, pc_o=0, is_in_delayslot_o=0, flush_o=0, new_pc_o=0.
  - state=IDLE, int_pending=0, both sync stages=0.
- Interrupt synchroniser: two flops per line; int_sync_o is the second stage (2-cycle latency).
- Forwarding: if wb_cp0_we_i and wb_cp0_waddr_i matches the Status (12), Cause (13) or EPC (14) address, use wb_cp0_data_i in place of that input.
  - For Cause, only bits [9:8] are taken from WB; all other bits come from cp0_cause_i.
- Effective IP: {int_sync_o, cause[9:8]}.
- int_req = status.IE(bit 0) & ~status.EXL(bit 1) & |(IP & status[15:8]).
- int_pending: set when int_req=1 and no valid instruction is in MEM; cleared when the interrupt is taken or int_req drops.
- Priority, combinational, in IDLE with mem_valid_i=1; emit the first that applies:
  1. interrupt (int_req | int_pending) → 0x01
  2. inst_invalid → 0x0a
  3. syscall → 0x08
  4. break → 0x09
  5. trap → 0x0d
  6. overflow → 0x0c
  7. eret → 0x0e
  8. none → 0x00
- In IDLE with mem_valid_i=0: except_type_o=0.
- pc_o=mem_pc_i; is_in_delayslot_o=mem_in_delayslot_i.
- Same cycle as a nonzero code: flush_o=1.
  - new_pc_o = forwarded EPC for eret.
  - Otherwise new_pc_o = EXC_VEC_BOOT if status.BEV (bit 22) else EXC_VEC_NORM.
- FSM:
  - IDLE→SQUASH when except_type_o≠0.
  - SQUASH→IDLE unconditionally after 1 cycle.
  - In SQUASH: except_type_o=0 and flush_o=0; MEM inputs ignored; int_pending holds.
- Simultaneous events:
  - Interrupt beats any MEM flag.
  - A WB write to Status that clears IE in the same cycle suppresses the interrupt.
- Reset asserted mid-SQUASH returns the FSM to IDLE asynchronously.

Optional Feature:
- Macro CP0_TIMER_INT_EN.
  - Defined: timer_int_i is ORed into IP bit 7 (int_sync_o[5] path, after synchronisation of int_i[5]), so timer interrupts are taken.
  - Undefined: timer_int_i is ignored and IP7 is int_sync_o[5] only.

Test Plan:
- Reset, then Status=0x0000FF01, int_i=6'b000001 → int_sync_o[0]=1 after 2 clks. Next valid MEM pc=0x80001000 → except_type_o=0x01, flush_o=1, new_pc_o=0x80000180, then one SQUASH cycle.
- mem_exc_i={inst_invalid, syscall} both set, Status.BEV=1 → except_type_o=0x0a, new_pc_o=0xBFC00380.
- eret in MEM, cp0_epc_i=0x80000010, WB writes EPC=0x80002000 same cycle → except_type_o=0x0e, new_pc_o=0x80002000.
- int_req with mem_valid_i=0 for 3 cycles → no flush and int_pending=1. First valid MEM pc=0x80000400 → code 0x01, pc_o=0x80000400.
- Status.EXL=1 with interrupt asserted → no interrupt taken. overflow in MEM, delayslot=1 → code 0x0c, is_in_delayslot_o=1.
- With CP0_TIMER_INT_EN defined, timer_int_i=1 and Status=0x00008001 → code 0x01. Undefined → code 0x00.
